axi_pmu_reader: RTL and testbench

//  AXI read-channel responder that makes the axi_pmu counter bank readable by a bus master.

---
 rtl/axi_pmu_pkg.sv | 37 +++
 rtl/axi_pmu_reader_if.sv | 31 +++
 rtl/axi_pmu_reader.sv | 152 +++++++++++++++
 tb/tb_axi_pmu_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pmu_pkg.sv
// Shared PMU definitions: counter select codes, AXI response codes
// and the reader FSM state type.
package axi_pmu_pkg;

    localparam int PMU_NUM_COUNTERS = 19;
    localparam int PMU_ADDR_WIDTH   = 5;

    localparam logic [4:0] RC_IDLE    = 5'd0;
    localparam logic [4:0] RC_BUSY    = 5'd1;
    localparam logic [4:0] RC_STALL   = 5'd2;
    localparam logic [4:0] AR_CNT     = 5'd3;
    localparam logic [4:0] AW_CNT     = 5'd4;
    localparam logic [4:0] W_CNT      = 5'd5;
    localparam logic [4:0] R_CNT      = 5'd6;
    localparam logic [4:0] B_CNT      = 5'd7;
    localparam logic [4:0] AR_STALL   = 5'd8;
    localparam logic [4:0] AW_STALL   = 5'd9;
    localparam logic [4:0] W_STALL    = 5'd10;
    localparam logic [4:0] R_STALL    = 5'd11;
    localparam logic [4:0] B_STALL    = 5'd12;
    localparam logic [4:0] RD_LAT_SUM = 5'd13;
    localparam logic [4:0] RD_LAT_MAX = 5'd14;
    localparam logic [4:0] WR_LAT_SUM = 5'd15;
    localparam logic [4:0] WR_LAT_MAX = 5'd16;
    localparam logic [4:0] ERR_CNT    = 5'd17;
    localparam logic [4:0] CLOCK_CNT  = 5'd18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        BEAT
    } state_t;

endpackage

// File: rtl/axi_pmu_reader_if.sv
// AXI read address/data channels of the PMU reader.
// Write channels are tied off in the fabric.
interface axi_pmu_reader_if #(
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();

    logic                  s_arvalid;
    logic                  s_arready;
    logic [ID_R_WIDTH-1:0] s_arid;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [7:0]            s_arlen;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [ID_R_WIDTH-1:0] s_rid;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rlast;

    modport slave (
        input  s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
        output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
    );

    modport master (
        output s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
        input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
    );

endinterface

// File: rtl/axi_pmu_reader.sv
// AXI read responder exposing the PMU counter bank, with a
// high-word shadow so lo-then-hi 32-bit reads are atomic.
module axi_pmu_reader #(
    parameter int ID_R_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_COUNTERS   = axi_pmu_pkg::PMU_NUM_COUNTERS,
    parameter int PMU_ADDR_WIDTH = axi_pmu_pkg::PMU_ADDR_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axi_pmu_reader_if.slave           axi,
    output logic [PMU_ADDR_WIDTH-1:0] pmu_addr_o,
    input  logic [63:0]               pmu_data_i
);

    import axi_pmu_pkg::*;

    localparam int WPC = 64 / DATA_WIDTH;
    localparam int BSH = $clog2(DATA_WIDTH / 8);
    localparam int HSH = (WPC == 2) ? 1 : 0;
    localparam int WW  = ADDR_WIDTH - BSH;
    localparam logic [WW-1:0] NC = WW'(NUM_COUNTERS);

    state_t                state_q, state_d;
    logic                  arready_q, arready_d;
    logic [WW-1:0]         word_q, word_d;
    logic [7:0]            beats_q, beats_d;
    logic [ID_R_WIDTH-1:0] id_q, id_d;
    logic                  rvalid_q, rvalid_d;
    logic [ID_R_WIDTH-1:0] rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [WW-1:0]         sidx_q, sidx_d;
    logic                  sval_q, sval_d;

    logic [WW-1:0] idx;
    logic          half;

    assign idx  = word_q >> HSH;
    assign half = (WPC == 2) ? word_q[0] : 1'b0;

    assign pmu_addr_o    = idx[PMU_ADDR_WIDTH-1:0];
    assign axi.s_arready = arready_q;
    assign axi.s_rvalid  = rvalid_q;
    assign axi.s_rid     = rid_q;
    assign axi.s_rdata   = rdata_q;
    assign axi.s_rresp   = rresp_q;
    assign axi.s_rlast   = rlast_q;

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        word_d    = word_q;
        beats_d   = beats_q;
        id_d      = id_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        shadow_d  = shadow_q;
        sidx_d    = sidx_q;
        sval_d    = sval_q;
        unique case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (axi.s_arvalid && arready_q) begin
                    id_d      = axi.s_arid;
                    word_d    = WW'(axi.s_araddr >> BSH);
                    beats_d   = axi.s_arlen;
                    arready_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                rresp_d = RESP_OKAY;
                if (idx >= NC) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else if (WPC == 1) begin
                    rdata_d = pmu_data_i[DATA_WIDTH-1:0];
                end else if (!half) begin
                    rdata_d  = DATA_WIDTH'(pmu_data_i[31:0]);
                    shadow_d = pmu_data_i[63:32];
                    sidx_d   = idx;
                    sval_d   = 1'b1;
                end else begin
                    // Serve the hi word captured with the lo word if it matches
                    if (sval_q && sidx_q == idx)
                        rdata_d = DATA_WIDTH'(shadow_q);
                    else
                        rdata_d = DATA_WIDTH'(pmu_data_i[63:32]);
                    sval_d = 1'b0;
                end
                rid_d    = id_q;
                rlast_d  = (beats_q == 8'd0);
                rvalid_d = 1'b1;
                state_d  = BEAT;
            end
            BEAT: begin
                if (axi.s_rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        word_d  = word_q + 1'b1;
                        beats_d = beats_q - 8'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            word_q    <= '0;
            beats_q   <= '0;
            id_q      <= '0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            shadow_q  <= '0;
            sidx_q    <= '0;
            sval_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            word_q    <= word_d;
            beats_q   <= beats_d;
            id_q      <= id_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            shadow_q  <= shadow_d;
            sidx_q    <= sidx_d;
            sval_q    <= sval_d;
        end
    end

endmodule

// File: tb/tb_axi_pmu_reader.sv
// Directed bench for axi_pmu_reader with a behavioural counter bank.
// Single-beat vectors from a table, multi-cycle cases by hand.
module tb_axi_pmu_reader;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [4:0]  pmu_addr;
    logic [63:0] pmu_data;
    logic [63:0] cnt [32];

    int checks = 0;
    int errors = 0;

    axi_pmu_reader_if #(
        .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)
    ) bus ();

    axi_pmu_reader #(
        .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32),
        .NUM_COUNTERS(19), .PMU_ADDR_WIDTH(5)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .axi(bus.slave),
        .pmu_addr_o(pmu_addr),
        .pmu_data_i(pmu_data)
    );

    assign pmu_data = cnt[pmu_addr];

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ar(input logic [3:0] id, input logic [15:0] addr,
                      input logic [7:0] len);
        int n = 0;
        bus.s_arvalid = 1'b1;
        bus.s_arid    = id;
        bus.s_araddr  = addr;
        bus.s_arlen   = len;
        while (bus.s_arready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ar_timeout", {63'd0, bus.s_arready}, 1);
        tick();
        bus.s_arvalid = 1'b0;
    endtask

    task automatic beat(input string nm, input logic [3:0] id,
                        input logic [31:0] d, input logic [1:0] r,
                        input logic l, input int stall);
        int n = 0;
        while (bus.s_rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_rvalid"}, bus.s_rvalid, 1);
        chk({nm, "_rdata"}, bus.s_rdata, d);
        chk({nm, "_rresp"}, bus.s_rresp, r);
        chk({nm, "_rlast"}, bus.s_rlast, l);
        chk({nm, "_rid"}, bus.s_rid, id);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({nm, "_stall_rvalid"}, bus.s_rvalid, 1);
            chk({nm, "_stall_rdata"}, bus.s_rdata, d);
            chk({nm, "_stall_rlast"}, bus.s_rlast, l);
        end
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.s_arvalid = 1'b0;
        bus.s_arid    = '0;
        bus.s_araddr  = '0;
        bus.s_arlen   = '0;
        bus.s_rready  = 1'b0;
        for (int i = 0; i < 32; i++) cnt[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 19; i++)
            cnt[i] = {32'hC0DE_0000 + 32'(i), 32'h1000_0000 + 32'(i)};

        vt[0]  = '{4'd1,  16'h0000, 32'h1000_0000, 2'b00};
        vt[1]  = '{4'd2,  16'h0004, 32'hC0DE_0000, 2'b00};
        vt[2]  = '{4'd3,  16'h002C, 32'hC0DE_0005, 2'b00};
        vt[3]  = '{4'd4,  16'h0028, 32'h1000_0005, 2'b00};
        vt[4]  = '{4'd5,  16'h0048, 32'h1000_0009, 2'b00};
        vt[5]  = '{4'd6,  16'h0094, 32'hC0DE_0012, 2'b00};
        vt[6]  = '{4'd7,  16'h0098, 32'h0000_0000, 2'b10};
        vt[7]  = '{4'd8,  16'hFFFC, 32'h0000_0000, 2'b10};
        vt[8]  = '{4'd9,  16'h0100, 32'h0000_0000, 2'b10};
        vt[9]  = '{4'd10, 16'h0093, 32'h1000_0012, 2'b00};
        vt[10] = '{4'd15, 16'h004C, 32'hC0DE_0009, 2'b00};

        tick();
        tick();
        chk("rst_arready", bus.s_arready, 0);
        chk("rst_rvalid", bus.s_rvalid, 0);
        chk("rst_rdata", bus.s_rdata, 0);
        chk("rst_rresp", bus.s_rresp, 0);
        chk("rst_rlast", bus.s_rlast, 0);
        chk("rst_rid", bus.s_rid, 0);
        chk("rst_pmu_addr", pmu_addr, 0);
        aresetn = 1'b1;
        #1;
        chk("rel_arready_pre", bus.s_arready, 0);
        tick();
        chk("rel_arready_post", bus.s_arready, 1);

        for (int i = 0; i < 11; i++) begin
            ar(vt[i].id, vt[i].addr, 8'd0);
            beat($sformatf("vec%0d", i), vt[i].id, vt[i].data,
                 vt[i].resp, 1'b1, 0);
        end

        // Address wrap: last word of the map rolls over to word 0
        ar(4'd9, 16'hFFFC, 8'd1);
        beat("wrap_b1", 4'd9, 32'h0, 2'b10, 1'b0, 0);
        beat("wrap_b2", 4'd9, 32'h1000_0000, 2'b00, 1'b1, 0);

        cnt[18] = 64'h0000_0007_0000_1234;
        ar(4'd5, 16'h0090, 8'd0);
        chk("t1_rvalid_n", bus.s_rvalid, 0);
        chk("t1_pmu_addr", pmu_addr, 18);
        tick();
        chk("t1_rvalid_n1", bus.s_rvalid, 1);
        beat("t1", 4'd5, 32'h0000_1234, 2'b00, 1'b1, 0);
        chk("t1_arready", bus.s_arready, 1);
        chk("t1_rvalid_end", bus.s_rvalid, 0);

        cnt[3] = 64'h0000_0001_FFFF_FFFF;
        ar(4'd1, 16'h0018, 8'd0);
        beat("t2_lo", 4'd1, 32'hFFFF_FFFF, 2'b00, 1'b1, 0);
        cnt[3] = 64'h0000_0002_0000_0000;
        ar(4'd1, 16'h001C, 8'd0);
        beat("t2_hi_shadow", 4'd1, 32'h1, 2'b00, 1'b1, 0);
        ar(4'd1, 16'h001C, 8'd0);
        beat("t2_hi_fresh", 4'd1, 32'h2, 2'b00, 1'b1, 0);

        cnt[0] = 64'hA0A0_0000_B0B0_0000;
        cnt[1] = 64'hA1A1_1111_B1B1_1111;
        ar(4'd7, 16'h0000, 8'd3);
        beat("t3_b1", 4'd7, 32'hB0B0_0000, 2'b00, 1'b0, 0);
        chk("t3_gap_m", bus.s_rvalid, 0);
        tick();
        chk("t3_gap_m1", bus.s_rvalid, 1);
        beat("t3_b2", 4'd7, 32'hA0A0_0000, 2'b00, 1'b0, 5);
        beat("t3_b3", 4'd7, 32'hB1B1_1111, 2'b00, 1'b0, 0);
        chk("t3_arready_mid", bus.s_arready, 0);
        beat("t3_b4", 4'd7, 32'hA1A1_1111, 2'b00, 1'b1, 0);

        ar(4'd2, 16'h0090, 8'd3);
        beat("t4_b1", 4'd2, 32'h0000_1234, 2'b00, 1'b0, 0);
        beat("t4_b2", 4'd2, 32'h0000_0007, 2'b00, 1'b0, 0);
        beat("t4_b3", 4'd2, 32'h0, 2'b10, 1'b0, 0);
        beat("t4_b4", 4'd2, 32'h0, 2'b10, 1'b1, 0);
        chk("t4_arready", bus.s_arready, 1);

        cnt[2] = 64'h2222_2222_0000_0002;
        cnt[4] = 64'h4444_4444_0000_0004;
        ar(4'd6, 16'h0010, 8'd0);
        beat("t5_lo_c2", 4'd6, 32'h2, 2'b00, 1'b1, 0);
        ar(4'd6, 16'h0024, 8'd0);
        beat("t5_hi_c4", 4'd6, 32'h4444_4444, 2'b00, 1'b1, 0);
        cnt[2] = 64'h5555_5555_0000_0002;
        ar(4'd6, 16'h0014, 8'd0);
        beat("t5_hi_c2", 4'd6, 32'h5555_5555, 2'b00, 1'b1, 0);

        ar(4'd3, 16'h0000, 8'd3);
        beat("t6_b1", 4'd3, 32'hB0B0_0000, 2'b00, 1'b0, 0);
        n = 0;
        while (bus.s_rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_b2_rvalid", bus.s_rvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_rvalid", bus.s_rvalid, 0);
        chk("t6_rst_arready", bus.s_arready, 0);
        cnt[0] = 64'hDEAD_BEEF_B0B0_0000;
        tick();
        aresetn = 1'b1;
        #1;
        chk("t6_rel_arready_pre", bus.s_arready, 0);
        tick();
        chk("t6_rel_arready_post", bus.s_arready, 1);
        ar(4'd3, 16'h0004, 8'd0);
        beat("t6_hi_live", 4'd3, 32'hDEAD_BEEF, 2'b00, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
